// File: rtl/branch_resolver_if.sv
// Execute-stage branch bus between the pipeline and branch_resolver.
// master drives EX operands, prediction info and the fetch lookup PC; slave is the resolver.
interface branch_resolver_if;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_pc;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    modport master (
        output stall, ex_valid, ex_pc, ex_instr, rs1_data, rs2_data,
               ex_pred_taken, ex_pred_pc, if_pc,
        input  if_pred_taken, redirect, redirect_pc, mispredict_cnt
    );

    modport slave (
        input  stall, ex_valid, ex_pc, ex_instr, rs1_data, rs2_data,
               ex_pred_taken, ex_pred_pc, if_pc,
        output if_pred_taken, redirect, redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// EX-stage resolution of BEQ/BNE/C.BEQZ/C.BNEZ: registered redirect on mispredict, saturating counter.
// Macro BRANCH_RESOLVER_BHT_EN adds the 2-bit direction-history table; otherwise fetch predicts not-taken.
module branch_resolver #(
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolver_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  instr;
    logic             is_b;
    logic             is_cb;
    logic             cond_ne;
    logic             operands_eq;
    logic             taken;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  fallthrough;
    logic [XLEN-1:0]  actual_next;
    logic             resolve;
    logic             mispredict;

    logic             redirect_q;
    logic             redirect_d;
    logic [XLEN-1:0]  redirect_pc_q;
    logic [XLEN-1:0]  redirect_pc_d;
    logic [CNT_W-1:0] mispredict_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_d;

    assign instr = bus.ex_instr;

    // Decode branch form, immediate and fallthrough step
    always_comb begin
        is_b        = 1'b0;
        is_cb       = 1'b0;
        cond_ne     = 1'b0;
        imm         = '0;
        fallthrough = bus.ex_pc + XLEN'(4);
        if (instr[1:0] == 2'b11) begin
            if (instr[6:0] == 7'b1100011 && instr[14:13] == 2'b00) begin
                is_b    = 1'b1;
                cond_ne = instr[12];
            end
            imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        end else if (instr[1:0] == 2'b01 && instr[15:14] == 2'b11) begin
            is_cb       = 1'b1;
            cond_ne     = instr[13];
            imm         = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
            fallthrough = bus.ex_pc + XLEN'(2);
        end
    end

    // CB forms compare against zero instead of rs2
    assign operands_eq = (bus.rs1_data == (is_cb ? '0 : bus.rs2_data));
    assign taken       = operands_eq ^ cond_ne;
    assign target      = bus.ex_pc + imm;
    assign actual_next = taken ? target : fallthrough;

    // EX contents during a redirect cycle are wrong-path and must not resolve
    assign resolve    = bus.ex_valid & (is_b | is_cb) & ~bus.stall & ~redirect_q;
    assign mispredict = resolve & (bus.ex_pred_pc != actual_next);

    always_comb begin
        redirect_d       = mispredict;
        redirect_pc_d    = redirect_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (mispredict) begin
            redirect_pc_d = actual_next;
            if (mispredict_cnt_q != CNT_MAX) begin
                mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q       <= 1'b0;
            redirect_pc_q    <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            redirect_q       <= redirect_d;
            redirect_pc_q    <= redirect_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.redirect       = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;

`ifdef BRANCH_RESOLVER_BHT_EN
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] if_idx;
    logic [1:0]       bht_cur;
    logic [1:0]       bht_nxt;

    assign ex_idx = bus.ex_pc[IDX_W:1];
    assign if_idx = bus.if_pc[IDX_W:1];

    // Saturating 2-bit update toward the resolved direction
    always_comb begin
        bht_cur = bht_q[ex_idx];
        bht_nxt = bht_cur;
        if (taken && bht_cur != 2'b11) begin
            bht_nxt = bht_cur + 2'd1;
        end else if (!taken && bht_cur != 2'b00) begin
            bht_nxt = bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (resolve) begin
            bht_q[ex_idx] <= bht_nxt;
        end
    end

    assign bus.if_pred_taken = bht_q[if_idx][1];
`else
    assign bus.if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expectations queued at drive time, popped after each clock edge.
`timescale 1ns/1ps
module tb_branch_resolver;
    localparam int unsigned BHT_N = 16;

    typedef enum int {K_NONE, K_BEQ, K_BNE, K_CBEQZ, K_CBNEZ} kind_e;
    typedef struct packed {
        logic        redirect;
        logic [31:0] rpc;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    branch_resolver_if bus();

    branch_resolver #(.BHT_ENTRIES(BHT_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_redirect;
    logic [31:0] m_rpc;
    logic [15:0] m_cnt;
    logic [1:0]  m_bht [BHT_N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input kind_e k, input logic [31:0] imm);
        logic [31:0] r;
        case (k)
            K_BEQ:   r = {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            K_BNE:   r = {imm[12], imm[10:5], 5'd2, 5'd1, 3'b001, imm[4:1], imm[11], 7'b1100011};
            K_CBEQZ: r = {16'hABCD, 3'b110, imm[8], imm[4:3], 3'b000, imm[7:6], imm[2:1], imm[5], 2'b01};
            K_CBNEZ: r = {16'hABCD, 3'b111, imm[8], imm[4:3], 3'b000, imm[7:6], imm[2:1], imm[5], 2'b01};
            default: r = 32'h0000_0013;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_redirect = 1'b0;
        m_rpc      = '0;
        m_cnt      = '0;
        for (int i = 0; i < int'(BHT_N); i++) m_bht[i] = 2'b01;
        sb_q.delete();
    endtask

    task automatic check_pred(input string tag, input logic [31:0] ipc);
        logic e;
`ifdef BRANCH_RESOLVER_BHT_EN
        e = m_bht[int'(ipc[4:1])][1];
`else
        e = 1'b0;
`endif
        chk(tag, 32'(bus.if_pred_taken), 32'(e));
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        n_checks++;
        assert (sb_q.size() > 0) else begin
            n_errors++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("redirect", 32'(bus.redirect), 32'(e.redirect));
            chk("redirect_pc", bus.redirect_pc, e.rpc);
            chk("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(e.cnt));
        end
    endtask

    // Apply one EX cycle, check the pre-edge table read, queue the post-edge expectation
    task automatic drive(input logic v, input logic st, input kind_e k, input logic [31:0] raw,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ppc, input logic [31:0] ipc);
        logic        br, tk, comp, res, mis;
        logic [31:0] nxt;
        int          idx;
        bus.stall         = st;
        bus.ex_valid      = v;
        bus.ex_pc         = pc;
        bus.ex_instr      = (k == K_NONE) ? raw : enc(k, imm);
        bus.rs1_data      = a;
        bus.rs2_data      = b;
        bus.ex_pred_pc    = ppc;
        bus.ex_pred_taken = (ppc != pc + 32'd4) && (ppc != pc + 32'd2);
        bus.if_pc         = ipc;
        #1;
        check_pred("if_pred_pre", ipc);
        br   = (k != K_NONE);
        comp = (k == K_CBEQZ) || (k == K_CBNEZ);
        case (k)
            K_BEQ:   tk = (a == b);
            K_BNE:   tk = (a != b);
            K_CBEQZ: tk = (a == 32'd0);
            K_CBNEZ: tk = (a != 32'd0);
            default: tk = 1'b0;
        endcase
        nxt = tk ? pc + imm : pc + (comp ? 32'd2 : 32'd4);
        res = v && br && !st && !m_redirect;
        mis = res && (ppc != nxt);
        if (res) begin
            idx = int'(pc[4:1]);
            if (tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
            else if (!tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
        end
        m_redirect = mis;
        if (mis) begin
            m_rpc = nxt;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        sb_q.push_back('{redirect: m_redirect, rpc: m_rpc, cnt: m_cnt});
        tick();
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(1'b0, 1'b0, K_NONE, 32'h0000_0013, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, ipc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_instr = 32'h13;
        bus.rs1_data = '0; bus.rs2_data = '0; bus.ex_pred_taken = 1'b0; bus.ex_pred_pc = '0;
        bus.if_pc = 32'h40;
        model_reset();
        #2;
        chk("rst_redirect", 32'(bus.redirect), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_cnt", 32'(bus.mispredict_cnt), 32'd0);
        chk("rst_if_pred", 32'(bus.if_pred_taken), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // BNE at 0x40 taken three times, correctly predicted
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, K_BNE, 32'h0, 32'h40, 32'd8, 32'd1, 32'd2, 32'h48, 32'h40);
        idle(32'h40);

        // BEQ mispredict, then wrong-path BNE during the redirect cycle
        drive(1'b1, 1'b0, K_BEQ, 32'h0, 32'h100, 32'd16, 32'd5, 32'd5, 32'h104, 32'h100);
        chk("beq_redirect", 32'(bus.redirect), 32'd1);
        chk("beq_redirect_pc", bus.redirect_pc, 32'h110);
        chk("beq_cnt", 32'(bus.mispredict_cnt), 32'd1);
        drive(1'b1, 1'b0, K_BNE, 32'h0, 32'h300, 32'hFFFF_FFF8, 32'd1, 32'd2, 32'h304, 32'h300);
        idle(32'h300);
        chk("squash_cnt", 32'(bus.mispredict_cnt), 32'd1);

        // C.BNEZ / C.BEQZ at 0x202 walk counter idx 1 through its floor and back up
        drive(1'b1, 1'b0, K_CBNEZ, 32'h0, 32'h202, 32'hFFFF_FFFA, 32'd0, 32'd9, 32'h204, 32'h202);
        drive(1'b1, 1'b0, K_CBNEZ, 32'h0, 32'h202, 32'hFFFF_FFFA, 32'd0, 32'd9, 32'h204, 32'h202);
        drive(1'b1, 1'b0, K_CBEQZ, 32'h0, 32'h202, 32'hFFFF_FFFA, 32'd0, 32'd9, 32'h1FC, 32'h202);
        drive(1'b1, 1'b0, K_CBEQZ, 32'h0, 32'h202, 32'hFFFF_FFFA, 32'd0, 32'd9, 32'h1FC, 32'h202);
        idle(32'h202);
        drive(1'b1, 1'b0, K_CBNEZ, 32'h0, 32'h202, 32'hFFFF_FFFA, 32'd7, 32'd0, 32'h204, 32'h202);
        chk("cbnez_redirect_pc", bus.redirect_pc, 32'h1FC);
        idle(32'h202);

        // Non-branches and invalid EX never redirect
        drive(1'b1, 1'b0, K_NONE, 32'h0080_006F, 32'h400, 32'h0, 32'd1, 32'd2, 32'h999, 32'h400);
        drive(1'b1, 1'b0, K_NONE, 32'h0020_C463, 32'h404, 32'h0, 32'd1, 32'd2, 32'h999, 32'h404);
        drive(1'b1, 1'b0, K_NONE, 32'h0000_A001, 32'h408, 32'h0, 32'd0, 32'd0, 32'h999, 32'h408);
        drive(1'b0, 1'b0, K_BEQ, 32'h0, 32'h40C, 32'd16, 32'd3, 32'd3, 32'h410, 32'h40C);
        idle(32'h40C);

        // Stall holds a mispredicting BEQ, release resolves it, stalled redirect still ends
        drive(1'b1, 1'b1, K_BEQ, 32'h0, 32'h500, 32'd32, 32'd3, 32'd3, 32'h504, 32'h500);
        drive(1'b1, 1'b1, K_BEQ, 32'h0, 32'h500, 32'd32, 32'd3, 32'd3, 32'h504, 32'h500);
        drive(1'b1, 1'b0, K_BEQ, 32'h0, 32'h500, 32'd32, 32'd3, 32'd3, 32'h504, 32'h500);
        chk("stall_release_pc", bus.redirect_pc, 32'h520);
        drive(1'b1, 1'b1, K_BEQ, 32'h0, 32'h500, 32'd32, 32'd3, 32'd3, 32'h504, 32'h500);
        idle(32'h500);

        // Counter saturation from a preset near the top
        force dut.mispredict_cnt_q = 16'hFFFE;
        #1;
        release dut.mispredict_cnt_q;
        m_cnt = 16'hFFFE;
        chk("preset_cnt", 32'(bus.mispredict_cnt), 32'h0000_FFFE);
        drive(1'b1, 1'b0, K_BEQ, 32'h0, 32'h600, 32'd8, 32'd1, 32'd1, 32'h604, 32'h600);
        idle(32'h600);
        drive(1'b1, 1'b0, K_BEQ, 32'h0, 32'h600, 32'd8, 32'd1, 32'd1, 32'h604, 32'h600);
        chk("sat_cnt", 32'(bus.mispredict_cnt), 32'h0000_FFFF);
        idle(32'h600);

        // Reset asserted while a redirect pulse is high
        drive(1'b1, 1'b0, K_BEQ, 32'h0, 32'h700, 32'd12, 32'd4, 32'd4, 32'h704, 32'h40);
        chk("pre_rst_redirect", 32'(bus.redirect), 32'd1);
        bus.if_pc = 32'h40;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_redirect", 32'(bus.redirect), 32'd0);
        chk("midrst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("midrst_cnt", 32'(bus.mispredict_cnt), 32'd0);
        chk("midrst_if_pred", 32'(bus.if_pred_taken), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, K_BEQ, 32'h0, 32'h700, 32'd12, 32'd4, 32'd4, 32'h704, 32'h40);
        idle(32'h700);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
